block_copy_ctrl: RTL and testbench
==================================

# block_copy_ctrl

Multi-cycle sequencer for the block-move and block-clear instructions. When the decoder pulses `Start`, it stalls the core and walks data memory one byte at a time. In copy mode it reads bytes from a source region and writes them to a destination region; in clear mode it writes zeros. It drives the write-data select mux: select 0 passes the captured byte, select 1 passes constant 0. The block sits beside data memory, and its address and write-enable outputs are OR'd or muxed in by the top level while `Busy` is high.

## Interface
- `ADDR_W`, 8, data memory address width; all address and length arithmetic is modulo 2^ADDR_W.
- `DATA_W`, 8, data memory word width.

- `Clk`  in  1  single system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high; forces the IDLE state and the reset values of all outputs immediately.
- `Start`  in  1  one-cycle request from decode; sampled only in IDLE.
- `Mode`  in  1  0 = copy, 1 = clear (zero-fill); latched with `Start`.
- `SrcAddr`  in  ADDR_W  source start address; latched with `Start`.
- `DstAddr`  in  ADDR_W  destination start address; latched with `Start`.
- `Len`  in  ADDR_W  byte count; 0 means no-op.
- `MemRdData`  in  DATA_W  data memory read port (combinational read of `MemAddr`).
- `MemAddr`  out  ADDR_W  data memory address while the block is active.
- `MemWrEn`  out  1  data memory write strobe.
- `ByteOut`  out  DATA_W  captured read byte; feeds mux input 0.
- `CopySel`  out  1  write-data mux select: 0 = `ByteOut`, 1 = zero.
- `Busy`  out  1  the block owns memory.
- `Stall`  out  1  combinational `Start` OR `Busy`, to the PC/fetch hold.
- `Done`  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, READ, WRITE, FIN.
- **IDLE:**
  - `Start`=1 latches `Mode`, `SrcAddr`, `DstAddr` and `Len`.
  - `Len`=0 goes to FIN.
  - Otherwise go to WRITE if `Mode`=1, else to READ.
- **READ:**
  - `MemAddr`=src pointer; `MemWrEn`=0.
  - On the edge, `ByteOut` <= `MemRdData` and src increments by 1.
  - Next state: WRITE.
- **WRITE:**
  - `MemAddr`=dst pointer; `MemWrEn`=1; `CopySel`=latched mode.
  - On the edge, dst increments by 1 and the remaining count decrements by 1.
  - If the remaining count was 1, go to FIN.
  - Otherwise go to READ (copy) or stay in WRITE (clear).
- **FIN:** `Done`=1, `Busy`=0, then IDLE.
- **`Busy`:** 1 in READ and WRITE only.
- **Address outputs outside READ/WRITE:** `MemAddr`=0 and `MemWrEn`=0 in IDLE and FIN.
- **Pointer wrap:** pointers wrap modulo 2^ADDR_W (0xFF+1 = 0x00); no error is flagged.
- **Overlap:** transfers are strictly ascending byte by byte, with no overlap detection.
  - For dst = src+1 in copy mode, the first source byte is replicated across the region. This is defined behaviour; software must avoid such overlaps.
- **Start while active:** `Start` in READ, WRITE or FIN is ignored; there is no queue.
- **`ByteOut` hold:** `ByteOut` holds its last value outside READ.
- **`CopySel` outside WRITE:** `CopySel`=0 outside WRITE.
- **Reset values:** state=IDLE, pointers=0, count=0, `ByteOut`=0, `MemAddr`=0, `MemWrEn`=0, `CopySel`=0, `Busy`=0, `Done`=0.
  - `Stall` equals `Start` during reset.
- **Reset mid-transfer:** `MemWrEn` drops asynchronously. Bytes already written stay written, and the transfer is not resumed.

## Timing
- **Sampling:** `Start` is sampled in cycle 0 (IDLE). `Stall`=1 in cycle 0 combinationally.
- **Copy, N≥1:** READ/WRITE alternate in cycles 1..2N, with byte k written in cycle 2k. FIN is cycle 2N+1. Total latency is 2N+1 cycles after `Start`.
- **Clear, N≥1:** WRITE in cycles 1..N; FIN in cycle N+1.
- **Len=0:** FIN in cycle 1; no memory access.
- **Earliest restart:** next accepted `Start` is the cycle after FIN.
- **Write timing:** writes commit on the rising edge at the end of each WRITE cycle. `MemAddr` and `MemWrEn` are registered-state decodes and are stable for the whole cycle.

## Test plan
- **Copy:** memory[0x10..0x12] = A1,B2,C3; `Start`, `Mode`=0, `SrcAddr`=0x10, `DstAddr`=0x40, `Len`=3 -> `MemWrEn` pulses at cycles 2, 4, 6. mem[0x40..0x42] = A1,B2,C3. `Done` at cycle 7; `Busy` cycles 1-6.
- **Clear with wrap:** `Mode`=1, `DstAddr`=0xFE, `Len`=4 -> zeros written to 0xFE, 0xFF, 0x00, 0x01 in cycles 1-4 with `CopySel`=1. `Done` at cycle 5; 0x02 untouched.
- **Zero length:** `Len`=0 -> `Done` at cycle 1; `MemWrEn` never asserted; `Busy` stays 0.
- **Start while busy:** second `Start` with different operands at cycle 3 of a Len=3 copy -> ignored. Only the original 3 bytes move; single `Done`.
- **Reset mid-copy:** `Reset` asserted mid-cycle 3 of a Len=4 copy (0x20 -> 0x60) -> `MemWrEn`, `Busy` and `Stall` go 0 immediately. Only mem[0x60] is written, and a fresh `Start` after release works normally.
- **Overlapping copy:** src=0x30, dst=0x31, `Len`=3, mem[0x30]=5A -> mem[0x31..0x33] = 5A,5A,5A.

Source files
------------

// File: rtl/block_copy_ctrl.sv
// rtl/block_copy_ctrl.sv - byte-serial block move / block clear sequencer
// Stalls the core and walks data memory ascending, one byte per READ/WRITE step.
module block_copy_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Len,
  input  logic [DATA_W-1:0] MemRdData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic [DATA_W-1:0] ByteOut,
  output logic              CopySel,
  output logic              Busy,
  output logic              Stall,
  output logic              Done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   byte_q, byte_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    byte_d  = byte_q;
    MemAddr = '0;
    MemWrEn = 1'b0;
    CopySel = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          mode_d = Mode;
          src_d  = SrcAddr;
          dst_d  = DstAddr;
          cnt_d  = Len;
          if (Len == '0)
            state_d = FIN;
          else if (Mode)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        MemAddr = src_q;
        Busy    = 1'b1;
        byte_d  = MemRdData;
        src_d   = src_q + ADDR_W'(1);
        state_d = WRITE;
      end
      WRITE: begin
        MemAddr = dst_q;
        MemWrEn = 1'b1;
        CopySel = mode_q;
        Busy    = 1'b1;
        dst_d   = dst_q + ADDR_W'(1);
        cnt_d   = cnt_q - ADDR_W'(1);
        // Count is never zero here: Len=0 bypasses straight to FIN.
        if (cnt_q == ADDR_W'(1))
          state_d = FIN;
        else if (mode_q)
          state_d = WRITE;
        else
          state_d = READ;
      end
      FIN: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ByteOut = byte_q;
  assign Stall   = Start | Busy;

endmodule

// File: tb/tb_block_copy_ctrl.sv
// tb/tb_block_copy_ctrl.sv - directed self-checking bench for block_copy_ctrl
// Surrounds the DUT with a 256-byte data memory and the zero/byte write mux.
module tb_block_copy_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Mode;
  logic [7:0] SrcAddr, DstAddr, Len;
  logic [7:0] MemRdData;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] ByteOut;
  logic       CopySel;
  logic       Busy;
  logic       Stall;
  logic       Done;

  logic [7:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  logic [15:0] tr_wr, tr_busy, tr_done, tr_sel;
  int n_tests = 0;
  int n_fail  = 0;

  block_copy_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
    .MemRdData(MemRdData), .MemAddr(MemAddr), .MemWrEn(MemWrEn),
    .ByteOut(ByteOut), .CopySel(CopySel), .Busy(Busy),
    .Stall(Stall), .Done(Done)
  );

  always #5 Clk = ~Clk;

  assign MemRdData = mem[MemAddr];

  always @(posedge Clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (MemWrEn)
      mem[MemAddr] <= CopySel ? 8'h00 : ByteOut;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge Clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Cycle 0: drive the request and check the combinational stall.
  task automatic go(input logic m, input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    Mode    = m;
    SrcAddr = s;
    DstAddr = d;
    Len     = l;
    Start   = 1'b1;
    #1;
    chk("stall_cycle0", {31'd0, Stall}, 32'd1);
  endtask

  // Cycles 1..n, sampled 1 time unit after each rising edge; optional Start re-pulse.
  task automatic run(input int n, input int inj);
    tr_wr = '0; tr_busy = '0; tr_done = '0; tr_sel = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge Clk);
      #1;
      if (c == 1) Start = 1'b0;
      if (c == inj + 1) Start = 1'b0;
      tr_wr[c]   = MemWrEn;
      tr_busy[c] = Busy;
      tr_done[c] = Done;
      tr_sel[c]  = CopySel;
      if (c == inj) begin
        Mode = 1'b0; SrcAddr = 8'h00; DstAddr = 8'h80; Len = 8'd5;
        Start = 1'b1;
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b1; Mode = 1'b0;
    SrcAddr = '0; DstAddr = '0; Len = '0;
    #3;
    chk("rst_stall_eq_start", {31'd0, Stall}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_wren", {31'd0, MemWrEn}, 32'd0);
    chk("rst_addr", {24'd0, MemAddr}, 32'h0);
    chk("rst_byteout", {24'd0, ByteOut}, 32'h0);
    chk("rst_copysel", {31'd0, CopySel}, 32'd0);
    Start = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;

    // Copy 0x10..0x12 -> 0x40..0x42
    preload(8'h10, 8'hA1); preload(8'h11, 8'hB2); preload(8'h12, 8'hC3);
    preload(8'h43, 8'h66);
    go(1'b0, 8'h10, 8'h40, 8'd3);
    run(8, 0);
    chk("copy_wr_trace",   {16'd0, tr_wr},   32'h0054);
    chk("copy_busy_trace", {16'd0, tr_busy}, 32'h007E);
    chk("copy_done_trace", {16'd0, tr_done}, 32'h0080);
    chk("copy_sel_trace",  {16'd0, tr_sel},  32'h0000);
    chk("copy_mem40", {24'd0, mem[8'h40]}, 32'hA1);
    chk("copy_mem41", {24'd0, mem[8'h41]}, 32'hB2);
    chk("copy_mem42", {24'd0, mem[8'h42]}, 32'hC3);
    chk("copy_mem43_untouched", {24'd0, mem[8'h43]}, 32'h66);
    chk("byteout_hold", {24'd0, ByteOut}, 32'hC3);

    // Clear with wrap 0xFE..0x01
    preload(8'hFE, 8'h11); preload(8'hFF, 8'h11); preload(8'h00, 8'h11);
    preload(8'h01, 8'h11); preload(8'h02, 8'h11);
    go(1'b1, 8'h00, 8'hFE, 8'd4);
    run(6, 0);
    chk("clr_wr_trace",   {16'd0, tr_wr},   32'h001E);
    chk("clr_sel_trace",  {16'd0, tr_sel},  32'h001E);
    chk("clr_busy_trace", {16'd0, tr_busy}, 32'h001E);
    chk("clr_done_trace", {16'd0, tr_done}, 32'h0020);
    chk("clr_memFE", {24'd0, mem[8'hFE]}, 32'h00);
    chk("clr_memFF", {24'd0, mem[8'hFF]}, 32'h00);
    chk("clr_mem00", {24'd0, mem[8'h00]}, 32'h00);
    chk("clr_mem01", {24'd0, mem[8'h01]}, 32'h00);
    chk("clr_mem02_untouched", {24'd0, mem[8'h02]}, 32'h11);
    chk("clr_byteout_kept", {24'd0, ByteOut}, 32'hC3);

    // Zero length
    go(1'b0, 8'h10, 8'h40, 8'd0);
    run(3, 0);
    chk("zero_wr_trace",   {16'd0, tr_wr},   32'h0000);
    chk("zero_busy_trace", {16'd0, tr_busy}, 32'h0000);
    chk("zero_done_trace", {16'd0, tr_done}, 32'h0002);

    // Start while busy is ignored
    preload(8'h80, 8'h77);
    go(1'b0, 8'h10, 8'h50, 8'd3);
    run(10, 3);
    chk("busy_wr_trace",   {16'd0, tr_wr},   32'h0054);
    chk("busy_done_trace", {16'd0, tr_done}, 32'h0080);
    chk("busy_mem50", {24'd0, mem[8'h50]}, 32'hA1);
    chk("busy_mem52", {24'd0, mem[8'h52]}, 32'hC3);
    chk("busy_mem80_untouched", {24'd0, mem[8'h80]}, 32'h77);

    // Reset mid-copy, then a fresh transfer
    preload(8'h20, 8'h9C); preload(8'h21, 8'h8D);
    preload(8'h60, 8'h00); preload(8'h61, 8'hEE);
    go(1'b0, 8'h20, 8'h60, 8'd4);
    run(3, 0);
    #4;
    Reset = 1'b1;
    #1;
    chk("midrst_busy",  {31'd0, Busy},    32'd0);
    chk("midrst_wren",  {31'd0, MemWrEn}, 32'd0);
    chk("midrst_stall", {31'd0, Stall},   32'd0);
    chk("midrst_addr",  {24'd0, MemAddr}, 32'h0);
    chk("midrst_byteout", {24'd0, ByteOut}, 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("midrst_mem60", {24'd0, mem[8'h60]}, 32'h9C);
    chk("midrst_mem61_untouched", {24'd0, mem[8'h61]}, 32'hEE);
    preload(8'h70, 8'h00);
    go(1'b0, 8'h21, 8'h70, 8'd1);
    run(3, 0);
    chk("post_rst_wr_trace",   {16'd0, tr_wr},   32'h0004);
    chk("post_rst_done_trace", {16'd0, tr_done}, 32'h0008);
    chk("post_rst_mem70", {24'd0, mem[8'h70]}, 32'h8D);

    // Overlapping copy replicates the first byte
    preload(8'h30, 8'h5A); preload(8'h31, 8'h01);
    preload(8'h32, 8'h02); preload(8'h33, 8'h03); preload(8'h34, 8'h04);
    go(1'b0, 8'h30, 8'h31, 8'd3);
    run(8, 0);
    chk("ovl_mem31", {24'd0, mem[8'h31]}, 32'h5A);
    chk("ovl_mem32", {24'd0, mem[8'h32]}, 32'h5A);
    chk("ovl_mem33", {24'd0, mem[8'h33]}, 32'h5A);
    chk("ovl_mem34_untouched", {24'd0, mem[8'h34]}, 32'h04);
    chk("ovl_done_trace", {16'd0, tr_done}, 32'h0080);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
